elevator_floor_queue: RTL and testbench

ELEVATOR_FLOOR_QUEUE -- requirements
Module: elevator_floor_queue

---
 rtl/elevator_pkg.sv | 21 ++
 rtl/elevator_floor_queue_if.sv | 32 +++
 rtl/elevator_floor_queue_floor_search.sv | 42 ++++
 rtl/elevator_floor_queue.sv | 130 +++++++++++++
 tb/tb_elevator_floor_queue.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
// Module  : elevator_pkg
// Brief   : Shared constants and travel-direction encoding for the elevator
//           floor queue.
// Revision: 1.0 - initial release
// ============================================================================
package elevator_pkg;

  localparam int NUM_FLOORS = 7;
  localparam int FLOOR_W    = 3;

  // Encoding matches the direction output: 00 IDLE, 01 UP, 10 DOWN.
  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10
  } dir_e;

endpackage
`default_nettype wire

// File: rtl/elevator_floor_queue_if.sv
`default_nettype none
// ============================================================================
// Module  : elevator_floor_queue_if
// Brief   : Panel/controller-side signal bundle for the floor queue. The
//           master side drives requests and car position; the slave side is
//           the queue itself.
// Revision: 1.0 - initial release
// ============================================================================
interface elevator_floor_queue_if;
  import elevator_pkg::*;

  logic                  r_nwr;
  logic [FLOOR_W-1:0]    requested_floor;
  logic [FLOOR_W-1:0]    current_floor;
  logic                  arrived;
  logic [NUM_FLOORS-1:0] queue_status;
  logic [FLOOR_W-1:0]    next_floor;
  logic                  next_valid;
  dir_e                  direction;

  modport master (
    output r_nwr, requested_floor, current_floor, arrived,
    input  queue_status, next_floor, next_valid, direction
  );

  modport slave (
    input  r_nwr, requested_floor, current_floor, arrived,
    output queue_status, next_floor, next_valid, direction
  );

endinterface
`default_nettype wire

// File: rtl/elevator_floor_queue_floor_search.sv
`default_nettype none
// ============================================================================
// Module  : floor_search
// Brief   : Combinational scan of the pending-floor bitmap relative to the
//           car position: is anything above/below, and which floor is the
//           nearest one in each direction.
// Revision: 1.0 - initial release
// ============================================================================
module floor_search
  import elevator_pkg::*;
(
  input  logic [NUM_FLOORS-1:0] bitmap,
  input  logic [FLOOR_W-1:0]    cur,
  output logic                  any_above,
  output logic                  any_below,
  output logic [FLOOR_W-1:0]    lowest_above,
  output logic [FLOOR_W-1:0]    highest_below
);

  // Scan downward for "above" and upward for "below" so the last hit is the
  // floor nearest the car. Only floors 0..6 are ever produced.
  always_comb begin
    any_above     = 1'b0;
    any_below     = 1'b0;
    lowest_above  = '0;
    highest_below = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (bitmap[i] && (FLOOR_W'(i) > cur)) begin
        any_above    = 1'b1;
        lowest_above = FLOOR_W'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (bitmap[i] && (FLOOR_W'(i) < cur)) begin
        any_below     = 1'b1;
        highest_below = FLOOR_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/elevator_floor_queue.sv
`default_nettype none
// ============================================================================
// Module  : elevator_floor_queue
// Brief   : Pending-floor queue and travel-direction FSM for a 7-floor car.
//           Requests set bitmap bits, arrivals clear them (a simultaneous
//           request wins), and the FSM picks the next target floor from the
//           registered bitmap.
// Options : ELEVATOR_QUEUE_INVALID_FLAG_EN adds the sticky invalid_req output
//           flagging any request for floor 7.
// Revision: 1.0 - initial release
// ============================================================================
module elevator_floor_queue
  import elevator_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  elevator_floor_queue_if.slave bus
`ifdef ELEVATOR_QUEUE_INVALID_FLAG_EN
  ,
  output logic                  invalid_req
`endif
);

  localparam logic [FLOOR_W-1:0] c_num_floors = FLOOR_W'(NUM_FLOORS);

  logic [NUM_FLOORS-1:0] r_queue;
  logic [FLOOR_W-1:0]    r_next_floor;
  logic                  r_next_valid;
  dir_e                  r_direction;

  logic                  w_write;
  logic [NUM_FLOORS-1:0] w_set;
  logic [NUM_FLOORS-1:0] w_clr;
  logic                  w_any_above;
  logic                  w_any_below;
  logic [FLOOR_W-1:0]    w_lowest_above;
  logic [FLOOR_W-1:0]    w_highest_below;

  // Decode request and arrival into one-hot set/clear masks.
  always_comb begin
    w_write = !bus.r_nwr && (bus.requested_floor < c_num_floors);
    w_set   = '0;
    w_clr   = '0;
    if (w_write) begin
      w_set[bus.requested_floor] = 1'b1;
    end
    if (bus.arrived && (bus.current_floor < c_num_floors)) begin
      w_clr[bus.current_floor] = 1'b1;
    end
  end

  // Pending bitmap: clear first, then set, so a same-floor request wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_queue <= '0;
    end else begin
      r_queue <= (r_queue & ~w_clr) | w_set;
    end
  end

  floor_search u_floor_search (
    .bitmap        (r_queue),
    .cur           (bus.current_floor),
    .any_above     (w_any_above),
    .any_below     (w_any_below),
    .lowest_above  (w_lowest_above),
    .highest_below (w_highest_below)
  );

  // Direction FSM with registered target; UP/IDLE prefer upward, DOWN
  // prefers downward. Falling into IDLE with a non-empty queue means only
  // the current floor is pending, so it becomes the target.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_direction  <= DIR_IDLE;
      r_next_floor <= '0;
      r_next_valid <= 1'b0;
    end else begin
      r_next_valid <= |r_queue;
      case (r_direction)
        DIR_DOWN: begin
          if (w_any_below) begin
            r_direction  <= DIR_DOWN;
            r_next_floor <= w_highest_below;
          end else if (w_any_above) begin
            r_direction  <= DIR_UP;
            r_next_floor <= w_lowest_above;
          end else begin
            r_direction <= DIR_IDLE;
            if (|r_queue) r_next_floor <= bus.current_floor;
          end
        end
        default: begin
          if (w_any_above) begin
            r_direction  <= DIR_UP;
            r_next_floor <= w_lowest_above;
          end else if (w_any_below) begin
            r_direction  <= DIR_DOWN;
            r_next_floor <= w_highest_below;
          end else begin
            r_direction <= DIR_IDLE;
            if (|r_queue) r_next_floor <= bus.current_floor;
          end
        end
      endcase
    end
  end

  assign bus.queue_status = r_queue;
  assign bus.next_floor   = r_next_floor;
  assign bus.next_valid   = r_next_valid;
  assign bus.direction    = r_direction;

`ifdef ELEVATOR_QUEUE_INVALID_FLAG_EN
  logic r_invalid_req;

  // Sticky flag for floor-7 requests; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_invalid_req <= 1'b0;
    end else if (!bus.r_nwr && (bus.requested_floor == c_num_floors)) begin
      r_invalid_req <= 1'b1;
    end
  end

  assign invalid_req = r_invalid_req;
`endif

endmodule
`default_nettype wire

// File: tb/tb_elevator_floor_queue.sv
`default_nettype none
// ============================================================================
// Module  : tb_elevator_floor_queue
// Brief   : Self-checking bench for elevator_floor_queue: directed scenarios
//           with literal expectations plus randomized traffic compared every
//           cycle against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_elevator_floor_queue;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   cmp_en = 1'b0;

  elevator_floor_queue_if bus ();

`ifdef ELEVATOR_QUEUE_INVALID_FLAG_EN
  logic invalid_req;
  elevator_floor_queue dut (.clk(clk), .reset(reset), .bus(bus), .invalid_req(invalid_req));
`else
  elevator_floor_queue dut (.clk(clk), .reset(reset), .bus(bus));
`endif

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [6:0] m_q;
  int         m_dir;
  int         m_nf;
  logic       m_nv;
`ifdef ELEVATOR_QUEUE_INVALID_FLAG_EN
  logic       m_inv;
`endif

  function automatic int lo_above(logic [6:0] q, int cur);
    for (int f = cur + 1; f < 7; f++) if (q[f]) return f;
    return -1;
  endfunction

  function automatic int hi_below(logic [6:0] q, int cur);
    for (int f = cur - 1; f >= 0; f--) if (f < 7 && q[f]) return f;
    return -1;
  endfunction

  function automatic int nxt_dir(int d, logic [6:0] q, int cur);
    int a = lo_above(q, cur);
    int b = hi_below(q, cur);
    if (d == 2) return (b >= 0) ? 2 : ((a >= 0) ? 1 : 0);
    return (a >= 0) ? 1 : ((b >= 0) ? 2 : 0);
  endfunction

  function automatic int nxt_nf(int d, logic [6:0] q, int cur, int old);
    int nd = nxt_dir(d, q, cur);
    if (nd == 1) return lo_above(q, cur);
    if (nd == 2) return hi_below(q, cur);
    for (int f = 0; f < 7; f++) if (q[f]) return f;
    return old;
  endfunction

  function automatic logic [6:0] upd_q(logic [6:0] q, logic nwr, int rf, int cf, logic arr);
    logic [6:0] r = q;
    if (arr && cf < 7) r[cf] = 1'b0;
    if (!nwr && rf < 7) r[rf] = 1'b1;
    return r;
  endfunction

  // Model state advances on the same edges as the DUT.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q   <= '0;
      m_dir <= 0;
      m_nf  <= 0;
      m_nv  <= 1'b0;
`ifdef ELEVATOR_QUEUE_INVALID_FLAG_EN
      m_inv <= 1'b0;
`endif
    end else begin
      m_q   <= upd_q(m_q, bus.r_nwr, int'(bus.requested_floor), int'(bus.current_floor), bus.arrived);
      m_dir <= nxt_dir(m_dir, m_q, int'(bus.current_floor));
      m_nf  <= nxt_nf(m_dir, m_q, int'(bus.current_floor), m_nf);
      m_nv  <= (m_q != 7'h00);
`ifdef ELEVATOR_QUEUE_INVALID_FLAG_EN
      m_inv <= m_inv | (!bus.r_nwr && bus.requested_floor == 3'd7);
`endif
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_queue_status", {1'b0, bus.queue_status}, {1'b0, m_q});
      chk("model_direction", {6'd0, bus.direction}, 8'(m_dir));
      chk("model_next_floor", {5'd0, bus.next_floor}, 8'(m_nf));
      chk("model_next_valid", {7'd0, bus.next_valid}, {7'd0, m_nv});
`ifdef ELEVATOR_QUEUE_INVALID_FLAG_EN
      chk("model_invalid_req", {7'd0, invalid_req}, {7'd0, m_inv});
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic nwr, input logic [2:0] rf, input logic [2:0] cf, input logic arr);
    @(negedge clk);
    bus.r_nwr           = nwr;
    bus.requested_floor = rf;
    bus.current_floor   = cf;
    bus.arrived         = arr;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b1;
    bus.r_nwr   = 1'b1;
    bus.arrived = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bus.r_nwr           = 1'b1;
    bus.requested_floor = 3'd0;
    bus.current_floor   = 3'd0;
    bus.arrived         = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_queue_status", {1'b0, bus.queue_status}, 8'h00);
    chk("reset_direction", {6'd0, bus.direction}, 8'h00);
    chk("reset_next_valid", {7'd0, bus.next_valid}, 8'h00);
    reset  = 1'b0;
    cmp_en = 1'b1;

    // Write floor 4 with the car at floor 0.
    step(1'b0, 3'd4, 3'd0, 1'b0);
    step(1'b1, 3'd0, 3'd0, 1'b0);
    chk("w4_queue", {1'b0, bus.queue_status}, 8'h10);
    step(1'b1, 3'd0, 3'd0, 1'b0);
    chk("w4_direction", {6'd0, bus.direction}, 8'd1);
    chk("w4_next_floor", {5'd0, bus.next_floor}, 8'd4);
    chk("w4_next_valid", {7'd0, bus.next_valid}, 8'd1);

    // Pending {1,5}, car at 3 going up, then arrival at 5.
    do_reset();
    step(1'b0, 3'd5, 3'd3, 1'b0);
    step(1'b0, 3'd1, 3'd3, 1'b0);
    step(1'b1, 3'd0, 3'd3, 1'b0);
    step(1'b1, 3'd0, 3'd3, 1'b0);
    chk("up_direction", {6'd0, bus.direction}, 8'd1);
    chk("up_next_floor", {5'd0, bus.next_floor}, 8'd5);
    step(1'b1, 3'd0, 3'd5, 1'b1);
    step(1'b1, 3'd0, 3'd5, 1'b0);
    chk("arr5_direction", {6'd0, bus.direction}, 8'd2);
    chk("arr5_next_floor", {5'd0, bus.next_floor}, 8'd1);
    chk("arr5_queue", {1'b0, bus.queue_status}, 8'h02);

    // Write and clear of floor 2 in the same cycle: write wins.
    step(1'b0, 3'd2, 3'd2, 1'b1);
    step(1'b1, 3'd0, 3'd2, 1'b0);
    chk("wr_clr_same_floor", {7'd0, bus.queue_status[2]}, 8'd1);

    // Floor-7 write is ignored.
    step(1'b0, 3'd7, 3'd2, 1'b0);
    step(1'b1, 3'd0, 3'd2, 1'b0);
    chk("floor7_ignored", {1'b0, bus.queue_status}, 8'h06);
`ifdef ELEVATOR_QUEUE_INVALID_FLAG_EN
    chk("invalid_sticky", {7'd0, invalid_req}, 8'd1);
    step(1'b1, 3'd0, 3'd2, 1'b0);
    chk("invalid_still", {7'd0, invalid_req}, 8'd1);
    do_reset();
    chk("invalid_cleared", {7'd0, invalid_req}, 8'd0);
`endif

    // Top-floor boundary: only floor 6 pending with the car at 6.
    do_reset();
    step(1'b0, 3'd6, 3'd6, 1'b0);
    step(1'b1, 3'd0, 3'd6, 1'b0);
    step(1'b1, 3'd0, 3'd6, 1'b0);
    chk("top_next_floor", {5'd0, bus.next_floor}, 8'd6);
    chk("top_next_valid", {7'd0, bus.next_valid}, 8'd1);
    chk("top_direction", {6'd0, bus.direction}, 8'd0);
    step(1'b1, 3'd0, 3'd6, 1'b1);
    step(1'b1, 3'd0, 3'd6, 1'b0);
    chk("top_cleared_queue", {1'b0, bus.queue_status}, 8'h00);
    step(1'b1, 3'd0, 3'd6, 1'b0);
    chk("top_cleared_valid", {7'd0, bus.next_valid}, 8'd0);
    chk("top_cleared_dir", {6'd0, bus.direction}, 8'd0);
    chk("top_hold_floor", {5'd0, bus.next_floor}, 8'd6);

    // Asynchronous reset in the middle of a cycle.
    do_reset();
    step(1'b0, 3'd0, 3'd3, 1'b0);
    step(1'b0, 3'd3, 3'd3, 1'b0);
    step(1'b1, 3'd0, 3'd3, 1'b0);
    chk("pre_async_queue", {1'b0, bus.queue_status}, 8'h09);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_queue", {1'b0, bus.queue_status}, 8'h00);
    chk("async_next_floor", {5'd0, bus.next_floor}, 8'h00);
    chk("async_next_valid", {7'd0, bus.next_valid}, 8'h00);
    chk("async_direction", {6'd0, bus.direction}, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic; the car position wanders and arrivals are frequent.
    begin
      logic [2:0] cf;
      cf = 3'd0;
      for (int n = 0; n < 2000; n++) begin
        if ($urandom_range(0, 3) == 0) cf = 3'($urandom_range(0, 6));
        if ($urandom_range(0, 249) == 0) begin
          do_reset();
        end else begin
          step(($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)), cf,
               ($urandom_range(0, 3) == 0));
        end
      end
    end

    step(1'b1, 3'd0, 3'd0, 1'b0);
    step(1'b1, 3'd0, 3'd0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
